// File: rtl/delay_line_n.sv
// Runtime-selectable N-stage delay line with a primed flag that reports when the
// selected tap carries only data sampled since the last reset or clear.
module delay_line_n #(
  parameter int WIDTH     = 1,
  parameter int MAX_DELAY = 8,
  localparam int SEL_W    = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic             primed
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);

  logic [WIDTH-1:0] stage [MAX_DELAY];
  logic [SEL_W-1:0] fill_cnt;
  logic [SEL_W-1:0] d;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return (s > MAX_SEL) ? MAX_SEL : s;
  endfunction

  // Stage register: reset and clear flush data as well, so no X ever reaches a tap
  always_ff @(posedge clk) begin
    if (sys_rst || clear) begin
      for (int k = 0; k < MAX_DELAY; k++) stage[k] <= '0;
      fill_cnt <= '0;
    end else if (shift_en) begin
      stage[0] <= sig_in;
      for (int k = 1; k < MAX_DELAY; k++) stage[k] <= stage[k-1];
      if (fill_cnt != MAX_SEL) fill_cnt <= fill_cnt + SEL_W'(1);
    end
  end

  // Tap select: d=0 bypasses the registers entirely
  always_comb begin
    d       = clamp_sel(delay_sel);
    sig_out = sig_in;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (d == SEL_W'(k + 1)) sig_out = stage[k];
    end
    primed = (d == '0) || (fill_cnt >= d);
  end

endmodule

// File: tb/tb_delay_line_n.sv
// Self-checking bench for delay_line_n (WIDTH=4, MAX_DELAY=8) using a queue-based
// reference of the stage contents plus constant expectations for key scenarios.
module tb_delay_line_n;

  localparam int WIDTH     = 4;
  localparam int MAX_DELAY = 8;
  localparam int SEL_W     = 4;

  logic             clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             clear = 1'b0;
  logic             shift_en = 1'b0;
  logic [SEL_W-1:0] delay_sel = '0;
  logic [WIDTH-1:0] sig_in = '0;
  logic [WIDTH-1:0] sig_out;
  logic             primed;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] hist[$];
  int               fill = 0;
  logic [WIDTH-1:0] exp_out;
  logic             exp_primed;

  delay_line_n #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
    .clk(clk), .sys_rst(sys_rst), .clear(clear), .shift_en(shift_en),
    .delay_sel(delay_sel), .sig_in(sig_in), .sig_out(sig_out), .primed(primed)
  );

  always #5 clk = ~clk;

  // Apply inputs and predict outputs from the current model state.
  task automatic drive(input bit r, input bit c, input bit e,
                       input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] i);
    int d;
    sys_rst = r; clear = c; shift_en = e; delay_sel = s; sig_in = i;
    d = (int'(s) > MAX_DELAY) ? MAX_DELAY : int'(s);
    exp_out    = (d == 0) ? i : hist[d-1];
    exp_primed = (d == 0) || (fill >= d);
    #1;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (sys_rst || clear) begin
      hist = {};
      repeat (MAX_DELAY) hist.push_back('0);
      fill = 0;
    end else if (shift_en) begin
      hist.push_front(sig_in);
      void'(hist.pop_back());
      if (fill < MAX_DELAY) fill++;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 3, 4'h5); tick();
    drive(1, 0, 1, 3, 4'h5);
    tests++; if (sig_out !== 4'h0) begin fails++; $display("FAIL reset_out got=%0h exp=0", sig_out); end
    tests++; if (primed !== 1'b0) begin fails++; $display("FAIL reset_primed got=%0b exp=0", primed); end
    drive(1, 0, 1, 0, 4'h9);
    tests++; if (sig_out !== 4'h9) begin fails++; $display("FAIL reset_bypass_out got=%0h exp=9", sig_out); end
    tests++; if (primed !== 1'b1) begin fails++; $display("FAIL reset_bypass_primed got=%0b exp=1", primed); end
    tick();
  endtask

  task automatic test_latency();
    logic [WIDTH-1:0] eo [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    logic             ep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(1, 0, 0, 3, 0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 3, WIDTH'(i + 1));
      tests++; if (sig_out !== eo[i]) begin fails++; $display("FAIL latency_out cyc=%0d got=%0h exp=%0h", i, sig_out, eo[i]); end
      tests++; if (primed !== ep[i]) begin fails++; $display("FAIL latency_primed cyc=%0d got=%0b exp=%0b", i, primed, ep[i]); end
      tick();
    end
  endtask

  task automatic test_bypass_single();
    logic [WIDTH-1:0] v, prev;
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      v = WIDTH'($urandom_range(15));
      drive(0, 0, 1, 0, v);
      tests++; if (sig_out !== v) begin fails++; $display("FAIL bypass_out cyc=%0d got=%0h exp=%0h", i, sig_out, v); end
      tests++; if (primed !== 1'b1) begin fails++; $display("FAIL bypass_primed cyc=%0d got=%0b exp=1", i, primed); end
      tick();
    end
    drive(1, 0, 0, 1, 0); tick();
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      v = WIDTH'($urandom_range(15));
      drive(0, 0, 1, 1, v);
      tests++; if (sig_out !== prev) begin fails++; $display("FAIL single_out cyc=%0d got=%0h exp=%0h", i, sig_out, prev); end
      tests++; if (primed !== (i >= 1)) begin fails++; $display("FAIL single_primed cyc=%0d got=%0b exp=%0b", i, primed, i >= 1); end
      tick();
      prev = v;
    end
  endtask

  task automatic test_clamp();
    drive(1, 0, 0, 15, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 15, WIDTH'($urandom_range(15)));
      tests++; if (sig_out !== exp_out) begin fails++; $display("FAIL clamp_out cyc=%0d got=%0h exp=%0h", i, sig_out, exp_out); end
      tests++; if (primed !== exp_primed) begin fails++; $display("FAIL clamp_primed cyc=%0d got=%0b exp=%0b", i, primed, exp_primed); end
      tick();
    end
    drive(0, 0, 0, 15, 0);
    tests++; if (primed !== 1'b1) begin fails++; $display("FAIL clamp_saturated got=%0b exp=1", primed); end
    tests++; if (sig_out !== hist[MAX_DELAY-1]) begin fails++; $display("FAIL clamp_tap8 got=%0h exp=%0h", sig_out, hist[MAX_DELAY-1]); end
  endtask

  task automatic test_enable_gating();
    drive(1, 0, 0, 2, 0); tick();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, (i % 2) == 0, 2, WIDTH'(i + 1));
      tests++; if (sig_out !== exp_out) begin fails++; $display("FAIL gate_out cyc=%0d got=%0h exp=%0h", i, sig_out, exp_out); end
      tests++; if (primed !== exp_primed) begin fails++; $display("FAIL gate_primed cyc=%0d got=%0b exp=%0b", i, primed, exp_primed); end
      tick();
    end
    // Enabled cycles carried 1,3,5,7,9,11: stage[1] must hold 9.
    drive(0, 0, 0, 2, 0);
    tests++; if (sig_out !== 4'h9) begin fails++; $display("FAIL gate_hold got=%0h exp=9", sig_out); end
  endtask

  task automatic test_clear_priority();
    logic [WIDTH-1:0] eo [5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    for (int m = 0; m < 2; m++) begin
      drive(1, 0, 0, 4, 0); tick();
      for (int i = 0; i < 6; i++) begin
        drive(0, 0, 1, 4, WIDTH'(i + 3));
        tick();
      end
      drive(m == 1, 1, 1, 4, 4'hF); tick();
      for (int j = 0; j < 5; j++) begin
        drive(0, 0, 1, 4, WIDTH'(j + 1));
        tests++; if (sig_out !== eo[j]) begin fails++; $display("FAIL clear_out mode=%0d cyc=%0d got=%0h exp=%0h", m, j, sig_out, eo[j]); end
        tests++; if (primed !== (j >= 4)) begin fails++; $display("FAIL clear_primed mode=%0d cyc=%0d got=%0b exp=%0b", m, j, primed, j >= 4); end
        tick();
      end
    end
  endtask

  task automatic test_runtime_change();
    drive(1, 0, 0, 2, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 2, WIDTH'(10 + i));
      tests++; if (sig_out !== exp_out) begin fails++; $display("FAIL change_fill_out cyc=%0d got=%0h exp=%0h", i, sig_out, exp_out); end
      tick();
    end
    drive(0, 0, 0, 6, 0);
    tests++; if (primed !== 1'b0) begin fails++; $display("FAIL change_drop_primed got=%0b exp=0", primed); end
    tests++; if (sig_out !== 4'h0) begin fails++; $display("FAIL change_tap6_empty got=%0h exp=0", sig_out); end
    drive(0, 0, 1, 6, 4'hE);
    tests++; if (primed !== 1'b0) begin fails++; $display("FAIL change_wait1 got=%0b exp=0", primed); end
    tick();
    drive(0, 0, 1, 6, 4'hF);
    tests++; if (primed !== 1'b0) begin fails++; $display("FAIL change_wait2 got=%0b exp=0", primed); end
    tick();
    drive(0, 0, 0, 6, 0);
    tests++; if (primed !== 1'b1) begin fails++; $display("FAIL change_refill got=%0b exp=1", primed); end
    tests++; if (sig_out !== 4'hA) begin fails++; $display("FAIL change_tap6 got=%0h exp=a", sig_out); end
    drive(0, 0, 0, 2, 0);
    tests++; if (primed !== 1'b1) begin fails++; $display("FAIL change_back_primed got=%0b exp=1", primed); end
    tests++; if (sig_out !== 4'hE) begin fails++; $display("FAIL change_back_tap2 got=%0h exp=e", sig_out); end
    tick();
  endtask

  initial begin
    repeat (MAX_DELAY) hist.push_back('0);
    test_reset();
    test_latency();
    test_bypass_single();
    test_clamp();
    test_enable_gating();
    test_clear_priority();
    test_runtime_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_line_n.md
Name: delay_line_n

Overview:
- Parametrised successor of the single-stage signal delay used in the pulse_transmitter peripheral.
- Delays a WIDTH-bit bus by a runtime-selectable number of clock-enabled stages, from 0 to MAX_DELAY.
- Reports when the selected delay tap holds only genuinely sampled data (primed).
- Sits between the pulse-transmitter sequencer and the output pins to align or skew channels.

Parameters:
- WIDTH, 1, bit width of the delayed bus.
- MAX_DELAY, 8, number of physical stages; must be ≥1.
- SEL_W, $clog2(MAX_DELAY+1), width of delay_sel (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of stages and fill count; lower priority than sys_rst.
- shift_en  input  1  advance the delay line this cycle.
- delay_sel  input  SEL_W  selected delay in stages; values > MAX_DELAY clamp to MAX_DELAY.
- sig_in  input  WIDTH  input sample.
- sig_out  output  WIDTH  delayed sample.
- primed  output  1  high when sig_out comes from a stage written since the last reset/clear.

Behaviour:
- Storage:
  - stage[0..MAX_DELAY-1], each WIDTH bits.
  - fill_cnt, range 0..MAX_DELAY.
- Reset and clear:
  - sys_rst=1 at clk edge: all stages ← 0, fill_cnt ← 0.
  - Otherwise, clear=1 at clk edge: same effect as sys_rst. shift_en is ignored that cycle and sig_in is not captured.
- Shift (sys_rst=0, clear=0, shift_en=1):
  - stage[0] ← sig_in.
  - stage[k] ← stage[k-1] for k = 1..MAX_DELAY-1.
  - fill_cnt ← min(fill_cnt+1, MAX_DELAY), saturating with no wrap.
- Hold (shift_en=0): stages and fill_cnt unchanged.
- Tap select, combinational from registered state plus sig_in:
  - d = min(delay_sel, MAX_DELAY).
  - d=0: sig_out = sig_in (bypass, zero latency).
  - d≥1: sig_out = stage[d-1].
  - With shift_en held high, latency is exactly d cycles.
  - d=1 with shift_en=1 reproduces the existing single-stage delay cycle for cycle.
- primed = (d==0) OR (fill_cnt ≥ d), combinational.
- Reset values of outputs:
  - sig_out = 0 when d≥1. When d=0 it follows sig_in.
  - primed = 0 when d≥1, 1 when d=0.
- delay_sel change mid-stream:
  - Takes effect in the same cycle; no flush is triggered.
  - Increasing d past fill_cnt drops primed until the line fills.
  - Decreasing d never drops primed.
  - Data already in the stages is preserved.
- Simultaneous events:
  - sys_rst overrides clear and shift_en.
  - clear overrides shift_en.
- Reset mid-operation: all in-flight samples are lost. sig_out shows 0 the cycle after (d≥1).
- No X propagation: every stage holds a defined value from reset onward.

Test Plan:
- Basic latency (WIDTH=4, MAX_DELAY=8, delay_sel=3, shift_en=1):
  - Stimulus: after reset, drive sig_in = 1,2,3,4,5 on successive cycles.
  - Required: sig_out = 0,0,0,1,2,3…; primed rises on the edge of the 3rd shift.
- Bypass and single-stage equivalence:
  - delay_sel=0: sig_out equals sig_in in the same cycle, primed=1 even during reset.
  - delay_sel=1: sig_out equals sig_in delayed by one cycle, identical to the single-stage delay.
- Clamp and saturation:
  - Stimulus: delay_sel=15 (SEL_W=4), MAX_DELAY=8.
  - Required: behaves as d=8; after 20 shifts fill_cnt=8 (no wrap) and primed=1.
- Enable gating:
  - Stimulus: d=2, alternate shift_en 1/0 with sig_in incrementing every cycle.
  - Required: only values present on shift_en=1 cycles appear; sig_out holds during shift_en=0; primed after 2 enabled cycles.
- Clear/reset priority:
  - Stimulus: mid-stream with d=4, assert clear and shift_en together.
  - Required: next cycle sig_out=0, primed=0, and the sig_in from that cycle never appears.
  - Repeat with sys_rst and clear together: identical result.
- Runtime delay change:
  - Stimulus: line full with d=2, switch to d=6 after only 4 shifts since clear.
  - Required: primed drops immediately; sig_out shows stage[5]=0; primed returns after 2 more shifts. Switching back to d=2 keeps primed=1.
